// File: rtl/updown_count_sched.sv
// Round-robin scheduler sharing one up/down step counter between two requesters; optional UPDOWN_COUNT_SCHED_SATURATE_EN stops a run instead of wrapping.
// Latency: gnt one cycle after req is seen in IDLE, then one step per cycle for len cycles, then done.
// Backpressure: requests are level-held until gnt; requests seen while busy wait for the next IDLE cycle.
module updown_count_sched #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             S,
    output logic             step,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             sat
);

    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);
    localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             s_q, s_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             win;
    logic             sat_stop;

    // Tie goes to whoever was not granted last; otherwise the lone requester wins.
    assign win = (req0 && req1) ? ~last_q : req1;

`ifdef UPDOWN_COUNT_SCHED_SATURATE_EN
    logic wrap;
    assign wrap     = s_q ? (q_q == '1) : (q_q == '0);
    assign sat_stop = (state_q == RUN) && wrap;
`else
    assign sat_stop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        s_d     = s_q;
        last_d  = last_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = GRANT;
                    owner_d = win;
                    last_d  = win;
                    s_d     = win ? dir1 : dir0;
                    rem_d   = win ? len1 : len0;
                end
            end
            GRANT: begin
                state_d = (rem_q != '0) ? RUN : DONE;
            end
            RUN: begin
                if (sat_stop) begin
                    state_d = DONE;
                    rem_d   = '0;
                end else begin
                    q_d   = s_q ? (q_q + Q_ONE) : (q_q - Q_ONE);
                    rem_d = rem_q - L_ONE;
                    if (rem_q == L_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            s_q     <= s_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // S only moves on the IDLE->GRANT edge, so it is settled before any step.
    assign gnt0  = (state_q == GRANT) && !owner_q;
    assign gnt1  = (state_q == GRANT) &&  owner_q;
    assign done0 = (state_q == DONE)  && !owner_q;
    assign done1 = (state_q == DONE)  &&  owner_q;
    assign step  = (state_q == RUN)   && !sat_stop;
    assign sat   = sat_stop;
    assign busy  = (state_q != IDLE);
    assign S     = s_q;
    assign Q     = q_q;

endmodule

// File: tb/tb_updown_count_sched.sv
// Directed self-checking bench for updown_count_sched (both default and saturating builds).
module tb_updown_count_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, dir0 = 1'b0, dir1 = 1'b0;
    logic [3:0] len0 = '0, len1 = '0;
    logic       gnt0, gnt1, done0, done1, S, step, busy, sat;
    logic [2:0] Q;
    logic [2:0] qm = 3'd0;
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    updown_count_sched #(.WIDTH(3), .LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
        .len0(len0), .len1(len1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .S(S), .step(step), .Q(Q), .busy(busy), .sat(sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full requester-0 run from IDLE; dir0/len0 are scrambled right after gnt.
    task automatic do_run(input logic d, input logic [3:0] n);
        logic [2:0] q;
        q = qm;
        dir0 = d; len0 = n; req0 = 1'b1;
        tick();
        chk("gnt0", gnt0, 1); chk("gnt_other", gnt1, 0);
        chk("gnt_S", S, d); chk("gnt_busy", busy, 1); chk("gnt_step", step, 0);
        req0 = 1'b0; dir0 = ~d; len0 = 4'hF;
        for (int i = 0; i < int'(n); i++) begin
            tick();
            chk("run_step", step, 1); chk("run_S", S, d);
            chk("run_Q", Q, q); chk("run_sat", sat, 0);
            q = d ? q + 3'd1 : q - 3'd1;
        end
        tick();
        chk("done0", done0, 1); chk("done_step", step, 0); chk("done_Q", Q, q);
        tick();
        chk("idle_busy", busy, 0); chk("idle_done0", done0, 0); chk("idle_Q", Q, q);
        qm = q;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_Q", Q, 0); chk("rst_S", S, 0); chk("rst_busy", busy, 0);
        chk("rst_step", step, 0); chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
        chk("rst_done0", done0, 0); chk("rst_done1", done1, 0); chk("rst_sat", sat, 0);
        reset = 1'b1;
        qm = 3'd0;
    endtask

    initial begin
        do_reset();
        tick();

        // Up run of 5 from 0
        do_run(1'b1, 4'd5);

        // Tie from Q=0: req0 (2 up) wins, then req1 (3 down) after one IDLE cycle
        do_reset();
        req0 = 1; dir0 = 1; len0 = 4'd2;
        req1 = 1; dir1 = 0; len1 = 4'd3;
        tick();
        chk("tie_gnt0", gnt0, 1); chk("tie_gnt1", gnt1, 0);
        req0 = 0;
        tick(); chk("tie_r0_step", step, 1); chk("tie_r0_Q", Q, 0);
        tick(); chk("tie_r0_step2", step, 1); chk("tie_r0_Q2", Q, 1);
        tick(); chk("tie_done0", done0, 1); chk("tie_Q2", Q, 2);
        tick(); chk("tie_idle", busy, 0); chk("tie_idle_gnt1", gnt1, 0);
        tick(); chk("tie_gnt1_late", gnt1, 1); chk("tie_gnt1_S", S, 0);
        req1 = 0;
        tick(); chk("r1_step_a", step, 1); chk("r1_Q_a", Q, 2);
        tick(); chk("r1_step_b", step, 1); chk("r1_Q_b", Q, 1);
        tick();
`ifdef UPDOWN_COUNT_SCHED_SATURATE_EN
        chk("r1_sat_step", step, 0); chk("r1_sat", sat, 1); chk("r1_sat_Q", Q, 0);
        tick(); chk("r1_done1", done1, 1); chk("r1_final_Q", Q, 0); chk("r1_done_sat", sat, 0);
        qm = 3'd0;
`else
        chk("r1_step_c", step, 1); chk("r1_Q_c", Q, 0); chk("r1_sat", sat, 0);
        tick(); chk("r1_done1", done1, 1); chk("r1_final_Q", Q, 7);
        qm = 3'd7;
`endif
        tick(); chk("r1_idle", busy, 0);

        // Second tie goes to req0; both zero-length, req1 follows
        req0 = 1; len0 = 4'd0; req1 = 1; len1 = 4'd0;
        tick(); chk("tie2_gnt0", gnt0, 1); chk("tie2_gnt1", gnt1, 0);
        req0 = 0;
        tick(); chk("z0_done0", done0, 1); chk("z0_step", step, 0); chk("z0_busy", busy, 1);
        tick(); chk("z0_idle", busy, 0);
        tick(); chk("z1_gnt1", gnt1, 1);
        req1 = 0;
        tick(); chk("z1_done1", done1, 1); chk("z1_step", step, 0); chk("z1_Q", Q, qm);
        tick(); chk("z1_idle", busy, 0);

        // Bring Q to 6, then an up run of 4 across the top
`ifdef UPDOWN_COUNT_SCHED_SATURATE_EN
        do_run(1'b1, 4'd6);
        req0 = 1; dir0 = 1; len0 = 4'd4;
        tick(); chk("s_gnt0", gnt0, 1);
        req0 = 0;
        tick(); chk("s_step", step, 1); chk("s_Q6", Q, 6); chk("s_nosat", sat, 0);
        tick(); chk("s_stop_step", step, 0); chk("s_sat", sat, 1); chk("s_Q7", Q, 7);
        tick(); chk("s_done0", done0, 1); chk("s_done_sat", sat, 0); chk("s_done_Q", Q, 7);
        tick(); chk("s_idle", busy, 0);
        qm = 3'd7;
`else
        do_run(1'b0, 4'd1);
        chk("pre_wrap_Q", Q, 6);
        do_run(1'b1, 4'd4);
        chk("wrap_Q", Q, 2);
`endif

        // Reset mid-run after 2 of 6 down steps
        req0 = 1; dir0 = 0; len0 = 4'd6;
        tick(); chk("m_gnt0", gnt0, 1);
        req0 = 0;
        tick(); chk("m_step1", step, 1); chk("m_Q1", Q, qm);
        tick(); chk("m_step2", step, 1); chk("m_Q2", Q, qm - 3'd1);
        reset = 0;
        tick();
        chk("m_rst_Q", Q, 0); chk("m_rst_busy", busy, 0);
        chk("m_rst_done", done0, 0); chk("m_rst_step", step, 0); chk("m_rst_S", S, 0);
        tick(); chk("m_rst_done_b", done0, 0);
        reset = 1;
        qm = 3'd0;
        tick(); chk("m_post_done", done0, 0);
        do_run(1'b1, 4'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/updown_count_sched.md
# updown_count_sched

Synchronous scheduler that shares one up/down step counter between two requesters. Each requester asks for a run of N steps in a chosen direction. The block arbitrates round-robin and sequences the granted run as one step pulse per cycle, driving the direction select. It keeps the authoritative registered count and reports completion per requester. It sits between the control logic and the 3-bit up/down counter datapath, so direction changes never coincide with count edges.

## Interface
- WIDTH, 3, count width; Q wraps modulo 2^WIDTH
- LEN_W, 4, run-length field width; max run = 2^LEN_W-1 steps
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-low; sampled on rising clk
- req0, req1  in  1  request from requester 0/1; level, held until gnt
- dir0, dir1  in  1  run direction; 1 = up, 0 = down; stable while req high
- len0, len1  in  LEN_W  step count for the run; stable while req high
- gnt0, gnt1  out  1  one-cycle pulse: run accepted, dir/len latched
- done0, done1  out  1  one-cycle pulse: granted run finished
- S  out  1  direction select to counter; 1 = up, 0 = down
- step  out  1  one-cycle count-enable pulse
- Q  out  WIDTH  registered count value
- busy  out  1  high in any state other than IDLE
- sat  out  1  one-cycle pulse on saturation stop; constant 0 when the feature is compiled out

## Operation
- FSM states: IDLE, GRANT, RUN, DONE. Encoding is free.
- IDLE: if req0 or req1 is high, pick the winner, go to GRANT. Otherwise stay.
- Arbitration is round-robin. Pointer `last` holds the most recently granted requester.
  - Both requesting: grant the one that is not `last`.
  - One requesting: grant it.
  - `last` is 1 after reset, so req0 wins the first tie.
- GRANT: pulse the winner's gnt. Latch its dir into S and its len into the remaining-count register `rem`. Update `last`. Go to RUN if len != 0, else go to DONE.
- RUN: each cycle assert step. Q <= Q ± 1 (mod 2^WIDTH) at that edge, and `rem` decrements. When `rem` reaches 1 on a step cycle, go to DONE.
- DONE: pulse the owner's done. Go to IDLE.
- S changes only in GRANT, never in a cycle where step = 1. Between runs S holds its last value.
- Requests arriving while busy are ignored until the next IDLE cycle. A requester may drop req any time after its gnt.
- Reset (reset = 0 at a rising edge):
  - state = IDLE, Q = 0, S = 0, rem = 0, last = 1.
  - step, gnt*, done*, sat, busy all 0.
  - An in-flight run is discarded with no done pulse.
  - Reset overrides every other event in the same cycle.

## Timing
- Request sampled high in IDLE at cycle t:
  - gnt at t+1.
  - step at t+2 … t+1+len.
  - done at t+2+len.
  - IDLE again at t+3+len.
- len = 0: gnt at t+1, done at t+2, no step, Q unchanged.
- Q is visible updated in the cycle after each step pulse.
- Back-to-back runs: minimum 1 IDLE cycle between done and the next gnt. A pending req from the other requester is granted at that point.
- Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1. No flag.

## Configuration
- Macro UPDOWN_COUNT_SCHED_SATURATE_EN.
- Defined:
  - In RUN, a step that would wrap (Q = max with S = 1, or Q = 0 with S = 0) is suppressed: no step pulse, Q held.
  - sat pulses in that cycle and the FSM goes to DONE. done follows the next cycle.
  - The remaining steps are dropped.
- Undefined: Q wraps freely and sat is tied 0.

## Test plan
- Reset, then req0 = 1, dir0 = 1, len0 = 5 -> gnt0 one cycle later, then 5 consecutive step pulses with S = 1, Q = 5, done0 at t+7, busy low at t+8.
- Simultaneous req0 and req1 (req0 len 2 up, req1 len 3 down) from Q = 0 -> gnt0 first, Q = 2. Then gnt1 after one IDLE cycle, final Q = 7 (wrap through 0). Next tie is granted to req0.
- len1 = 0 -> gnt1 then done1 the next cycle, no step, Q unchanged.
- Q = 6, up run of len 4 -> Q sequence 7, 0, 1, 2, sat stays 0. With UPDOWN_COUNT_SCHED_SATURATE_EN: Q = 7, then sat pulse, then done, 3 steps dropped.
- Reset driven low mid-RUN after 2 of 6 steps -> next cycle Q = 0, IDLE, no done. A fresh req0 is granted normally afterwards.
- dir0/len0 changed after gnt0 while the run is in progress -> S and step count unaffected.
